prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-memory interface. It accepts a byte stream over a valid/ready
//  handshake and packs each pair of bytes into a 16-bit instruction word, high byte first.
//  Each word is written to program memory at consecutive addresses, starting at a given address.
//  It fills the memory that the fetch path later reads with pc/en -> ir_data before the core runs.
// PARAMETERS
//  AW        8     program memory address width (256 words)
//  CW        9     word-count width (allows counts 1..256)
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  rst          in   1    synchronous, active-high reset
//  load_start   in   1    1-cycle request to begin a load; sampled only in IDLE
//  start_addr   in   AW   first memory address, sampled with load_start
//  word_count   in   CW   number of 16-bit words to load, sampled with load_start
//  in_valid     in   1    byte on in_data is valid
//  in_data      in   8    stream byte
//  in_ready     out  1    loader accepts a byte this cycle (transfer = in_valid & in_ready)
//  mem_wr       out  1    program-memory write strobe, 1 cycle per word
//  mem_addr     out  AW   write address
//  mem_wdata    out  16   write data {hi_byte, lo_byte}
//  busy         out  1    load in progress
//  done         out  1    1-cycle pulse after the last word is written
//  err          out  1    sticky error flag, cleared by the next accepted load_start
//  err_code     out  2    00 none, 01 bad length/range, 10 illegal opcode
//  words_written out CW   words written in the current/last load
//  checksum     out  8    mod-256 sum of all accepted bytes in the current/last load
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: in_ready, mem_wr, mem_addr, mem_wdata, busy, done, err,
//   err_code, words_written, checksum.
//  FSM: IDLE -> HI -> LO -> WR -> (HI | DONE) ; DONE -> IDLE ; any error -> IDLE.
//  IDLE: load_start=1 clears err, err_code, words_written and checksum, and latches the address.
//   The load is rejected if word_count==0, or if start_addr+word_count>256 (past address 255).
//   On rejection: err=1, err_code=01, no write, and the FSM stays in IDLE.
//   Otherwise the next state is HI and busy=1.
//  HI: in_ready=1. On transfer: latch the high byte, checksum+=byte, go to LO.
//  LO: in_ready=1. On transfer: latch the low byte, checksum+=byte, go to WR.
//  WR: in_ready=0. mem_wr=1 for exactly one cycle with mem_addr=current address and the word.
//   words_written+1, address+1. If words_written reaches word_count, go to DONE, else go to HI.
//  DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
//  Latency: mem_wr is asserted the cycle after the low-byte transfer. Peak rate is 1 word per
//   3 cycles.
//  Address never wraps: the range check at start guarantees the last address is <=255.
//  load_start while busy is ignored; there is no queueing.
//  in_valid with in_ready=0 is not consumed; the byte must be held by the source.
//  Stalls are unbounded: the FSM waits in HI/LO indefinitely.
//  checksum wraps modulo 256. words_written holds its value after DONE until the next start.
//  rst mid-load: immediately returns to IDLE with reset values. Partially written memory is not
//   restored.
//  mem_addr/mem_wdata hold their last value when mem_wr=0.
// CONFIGURATION
//  OPCODE_CHECK_EN defined: in WR, hi_byte[7:4] is checked against the legal set
//   {0000 add, 0001 sub, 1000 load, 1010 inc, 1011 dec, 1100 hlt, 1110 jnz, 1111 jmp}.
//   An illegal opcode suppresses mem_wr, sets err=1 and err_code=10, gives busy=0 and no done
//   pulse, and returns the FSM to IDLE.
//   words_written excludes the rejected word.
//  OPCODE_CHECK_EN undefined: there is no opcode check, every word is written, and err_code=10
//   never occurs.
// TESTING
//  1. start_addr=0x10, count=2, bytes 80 05 00 12 -> mem_wr at 0x10=0x8005, 0x11=0x0012; done
//     pulse; words_written=2; checksum=0x97.
//  2. count=0, or start_addr=0xFF with count=2 -> err=1, err_code=01, no mem_wr, busy stays 0.
//  3. start_addr=0xFF, count=1, bytes C0 00 -> write 0xFF=0xC000, done; no wrap, no error.
//  4. in_valid toggled randomly (gaps of 0-5 cycles) for a 4-word load -> same writes as
//     back-to-back; in_ready=0 in WR.
//  5. rst asserted after the 1st word of a 3-word load -> next cycle all outputs 0 and
//     state IDLE; a fresh load then succeeds.
//  6. [OPCODE_CHECK_EN] word 0x2000 as the 2nd of 3 -> 1st written, err_code=10,
//     words_written=1, no done; undefined: all 3 written.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream to 16-bit program-memory writer (optional OPCODE_CHECK_EN)
// Packs byte pairs high-first into words and writes them to consecutive addresses.
module prog_loader #(
  parameter int AW = 8,
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW-1:0] start_addr,
  input  logic [CW-1:0] word_count,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [CW-1:0] words_written,
  output logic [7:0]    checksum
);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    lo_q, lo_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [CW-1:0] words_q, words_d;
  logic [7:0]    checksum_q, checksum_d;

  logic [CW:0]   end_addr;
  logic [CW-1:0] words_inc;
  logic          range_bad;

  // One past the last address; must not exceed the memory depth.
  assign end_addr  = {{(CW+1-AW){1'b0}}, start_addr} + {1'b0, word_count};
  assign range_bad = (word_count == '0) || (end_addr > ((CW+1)'(1) << AW));
  assign words_inc = words_q + {{(CW-1){1'b0}}, 1'b1};

`ifdef OPCODE_CHECK_EN
  logic opcode_ok;
  always_comb begin
    case (hi_q[7:4])
      4'b0000, 4'b0001, 4'b1000, 4'b1010,
      4'b1011, 4'b1100, 4'b1110, 4'b1111: opcode_ok = 1'b1;
      default:                            opcode_ok = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    words_d     = words_q;
    checksum_d  = checksum_q;
    in_ready    = 1'b0;
    mem_wr      = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          err_d      = 1'b0;
          err_code_d = 2'b00;
          words_d    = '0;
          checksum_d = 8'h00;
          addr_d     = start_addr;
          count_d    = word_count;
          if (range_bad) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_d       = in_data;
          checksum_d = checksum_q + in_data;
          state_d    = S_LO;
        end
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lo_d       = in_data;
          checksum_d = checksum_q + in_data;
          state_d    = S_WR;
        end
      end
      S_WR: begin
`ifdef OPCODE_CHECK_EN
        if (!opcode_ok) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end else
`endif
        begin
          mem_wr      = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = {hi_q, lo_q};
          words_d     = words_inc;
          addr_d      = addr_q + {{(AW-1){1'b0}}, 1'b1};
          state_d     = (words_inc == count_q) ? S_DONE : S_HI;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write port shows the live word during WR and holds it afterwards.
  assign mem_addr      = mem_wr ? addr_q : mem_addr_q;
  assign mem_wdata     = mem_wr ? {hi_q, lo_q} : mem_wdata_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign words_written = words_q;
  assign checksum      = checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      words_q     <= '0;
      checksum_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      words_q     <= words_d;
      checksum_q  <= checksum_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] start_addr;
  logic [8:0] word_count;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_wr, busy, done, err;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0] err_code;
  logic [8:0] words_written;
  logic [7:0] checksum;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [23:0] exp_q[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .start_addr(start_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .words_written(words_written), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected {addr, data}.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (mem_wr) begin
        chk("in_ready_in_wr", {63'd0, in_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {40'd0, mem_addr, mem_wdata}, 64'hFFFF_FFFF);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          chk("write", {40'd0, mem_addr, mem_wdata}, {40'd0, e});
        end
      end
    end
  end

  task automatic start(input logic [7:0] a, input logic [8:0] n);
    load_start = 1'b1; start_addr = a; word_count = n;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = b;
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    chk("byte_accept_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] a, input logic [15:0] w, input bit expect_wr,
                           input int g0, input int g1);
    if (expect_wr) exp_q.push_back({a, w});
    send_byte(w[15:8], g0);
    send_byte(w[7:0], g1);
  endtask

  task automatic wait_done(input string name, input logic [8:0] nw, input logic [7:0] cs);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_words"}, {55'd0, words_written}, {55'd0, nw});
    chk({name, "_checksum"}, {56'd0, checksum}, {56'd0, cs});
    chk({name, "_err"}, {63'd0, err}, 64'd0);
    @(negedge clk);
    chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {16'd0, in_ready, mem_wr, mem_addr, mem_wdata, busy, done, err, err_code,
               words_written, checksum}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; start_addr = 8'h00; word_count = 9'd0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // 1: basic two-word load
    start(8'h10, 9'd2);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    send_word(8'h10, 16'h8005, 1'b1, 0, 0);
    send_word(8'h11, 16'h0012, 1'b1, 0, 0);
    wait_done("t1", 9'd2, 8'h97);

    // 2: rejected lengths/ranges
    start(8'h20, 9'd0);
    chk("t2a_err", {61'd0, err, err_code}, {61'd0, 3'b101});
    chk("t2a_busy", {63'd0, busy}, 64'd0);
    start(8'hFF, 9'd2);
    chk("t2b_err", {61'd0, err, err_code}, {61'd0, 3'b101});
    chk("t2b_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);

    // 3: last address, no wrap; accepted start clears err
    start(8'hFF, 9'd1);
    chk("t3_err_cleared", {61'd0, err, err_code}, 64'd0);
    send_word(8'hFF, 16'hC000, 1'b1, 0, 0);
    wait_done("t3", 9'd1, 8'hC0);

    // 4: stalled stream
    start(8'h20, 9'd4);
    send_word(8'h20, 16'h8001, 1'b1, 0, 3);
    send_word(8'h21, 16'hA002, 1'b1, 5, 1);
    send_word(8'h22, 16'hB003, 1'b1, 2, 4);
    send_word(8'h23, 16'hE004, 1'b1, 0, 5);
    wait_done("t4", 9'd4, 8'hBA);

    // 5: reset mid-load, then a fresh load
    start(8'h40, 9'd3);
    send_word(8'h40, 16'h1111, 1'b1, 0, 0);
    for (int n = 0; n < 20 && words_written != 9'd1; n++) @(negedge clk);
    chk("t5_first_word", {55'd0, words_written}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_after_rst");
    rst = 1'b0;
    @(negedge clk);
    start(8'h50, 9'd1);
    send_word(8'h50, 16'hC123, 1'b1, 0, 0);
    wait_done("t5", 9'd1, 8'hE4);

    // 6: illegal opcode in the second word
    done_cnt = 0;
    start(8'h60, 9'd3);
    send_word(8'h60, 16'h0001, 1'b1, 0, 0);
`ifdef OPCODE_CHECK_EN
    send_word(8'h61, 16'h2000, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    chk("t6_err", {61'd0, err, err_code}, {61'd0, 3'b110});
    chk("t6_words", {55'd0, words_written}, 64'd1);
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
`else
    send_word(8'h61, 16'h2000, 1'b1, 0, 0);
    send_word(8'h62, 16'hF003, 1'b1, 0, 0);
    wait_done("t6", 9'd3, 8'h14);
`endif

    repeat (3) @(negedge clk);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
